pll_supervisor: RTL and testbench

- Runs on the raw reference clock alongside an SB_PLL40_CORE wrapper.
- Sequences the PLL reset and qualifies LOCK with a stability filter.
- Retries on lock timeout and releases a synchronous system reset only after a stable lock.
- Detects lock loss at runtime and optionally falls back to PLL bypass when retries are exhausted, which the bare PLL wrapper cannot do.

---
 rtl/pll_supervisor_pkg.sv | 27 ++
 rtl/sync_2ff.sv | 37 +++
 rtl/pll_supervisor.sv | 169 ++++++++++++++++
 tb/tb_pll_supervisor.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_supervisor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_supervisor_pkg
// Description : Shared definitions for the PLL supervisor. Holds the state
//               encoding observed on the STATE port and a helper that sizes
//               the internal counters from their terminal values.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_supervisor_pkg;

    // The STATE port exposes this encoding directly, so the values are fixed.
    typedef enum logic [2:0] {
        ST_HOLD   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAILED = 3'd4
    } state_t;

    // Bits needed to hold the values 0..n-1. The result is at least 1 so that
    // degenerate parameter choices still produce legal vectors.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : pll_supervisor_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchroniser for asynchronous inputs, with an
//               asynchronous active-low reset that clears both stages.
// Ports       : clk   - destination clock
//               rst_n - asynchronous reset, active low
//               i_d   - asynchronous input bus (bits synchronised separately)
//               o_q   - synchronised output, two clk edges of latency
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/pll_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : pll_supervisor
// Description : Sequences the reset of an SB_PLL40_CORE, qualifies its LOCK
//               output with a stability filter, retries on lock timeout and
//               releases the system reset only after a stable lock. Lock loss
//               in operation restarts sequencing; exhausted retries park the
//               PLL in reset and optionally run the system in bypass.
// Ports       : REFERENCECLK - sole clock, PLL reference clock
//               RESET        - asynchronous reset, active low
//               LOCK         - PLL lock, asynchronous to REFERENCECLK
//               RETRY_REQ    - one-cycle pulse, restarts from FAILED
//               PLL_RESETB   - PLL reset, active low
//               PLL_BYPASS   - PLL bypass select
//               SYS_RESETN   - registered system reset, active low
//               STATE        - current state encoding
//               FAILED       - high while in the failed state
//               RELOCK_COUNT - saturating count of runtime lock losses
// Revision    : 1.0 - initial release
// ============================================================================
module pll_supervisor
    import pll_supervisor_pkg::*;
#(
    parameter int RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT    = 4096,
    parameter int LOCK_STABLE     = 256,
    parameter int MAX_RETRIES     = 3,
    parameter bit FALLBACK_BYPASS = 1'b1,
    parameter int CNT_W           = 8
) (
    input  logic             REFERENCECLK,
    input  logic             RESET,
    input  logic             LOCK,
    input  logic             RETRY_REQ,
    output logic             PLL_RESETB,
    output logic             PLL_BYPASS,
    output logic             SYS_RESETN,
    output logic [2:0]       STATE,
    output logic             FAILED,
    output logic [CNT_W-1:0] RELOCK_COUNT
);

    localparam int HOLD_W = cnt_w(RST_CYCLES);
    localparam int TMO_W  = cnt_w(LOCK_TIMEOUT);
    // stab_cnt is compared against LOCK_STABLE itself, so it needs one extra value.
    localparam int STB_W  = cnt_w(LOCK_STABLE + 1);
    localparam int RTY_W  = cnt_w(MAX_RETRIES + 1);

    state_t             r_state,     w_state_nxt;
    logic [HOLD_W-1:0]  r_hold_cnt,  w_hold_nxt;
    logic [TMO_W-1:0]   r_tmo_cnt,   w_tmo_nxt;
    logic [STB_W-1:0]   r_stab_cnt,  w_stab_nxt;
    logic [RTY_W-1:0]   r_retry_cnt, w_retry_nxt;
    logic [CNT_W-1:0]   r_relock,    w_relock_nxt;
    logic [STB_W-1:0]   w_stab_inc;
    logic               w_timeout;
    logic               w_lock_s;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk   (REFERENCECLK),
        .rst_n (RESET),
        .i_d   (LOCK),
        .o_q   (w_lock_s)
    );

    // Leaving WAIT on a synchronised-high sample counts that sample as the
    // first; in STABLE every further high sample adds one.
    assign w_stab_inc = (r_state == ST_WAIT) ? STB_W'(1) : r_stab_cnt + STB_W'(1);
    assign w_timeout  = (r_tmo_cnt == TMO_W'(LOCK_TIMEOUT - 1));

    always_comb begin
        w_state_nxt  = r_state;
        w_hold_nxt   = '0;
        w_tmo_nxt    = '0;
        w_stab_nxt   = '0;
        w_retry_nxt  = r_retry_cnt;
        w_relock_nxt = r_relock;
        case (r_state)
            ST_HOLD: begin
                if (r_hold_cnt == HOLD_W'(RST_CYCLES - 1)) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            ST_WAIT, ST_STABLE: begin
                // The timeout window spans WAIT and STABLE together; a chatter
                // return to WAIT keeps the elapsed time.
                w_tmo_nxt = r_tmo_cnt + TMO_W'(1);
                if (w_lock_s) begin
                    w_stab_nxt  = w_stab_inc;
                    w_state_nxt = (w_stab_inc == STB_W'(LOCK_STABLE)) ? ST_RUN : ST_STABLE;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
                // A qualification completing on the last window cycle wins.
                if (w_timeout && (w_state_nxt != ST_RUN)) begin
                    w_tmo_nxt  = '0;
                    w_stab_nxt = '0;
                    if (r_retry_cnt == RTY_W'(MAX_RETRIES)) begin
                        w_state_nxt = ST_FAILED;
                    end else begin
                        w_retry_nxt = r_retry_cnt + RTY_W'(1);
                        w_state_nxt = ST_HOLD;
                    end
                end
                if (w_state_nxt == ST_RUN) begin
                    w_tmo_nxt   = '0;
                    w_stab_nxt  = '0;
                    w_retry_nxt = '0;
                end
            end
            ST_RUN: begin
                if (!w_lock_s) begin
                    w_state_nxt = ST_HOLD;
                    if (r_relock != {CNT_W{1'b1}}) begin
                        w_relock_nxt = r_relock + CNT_W'(1);
                    end
                end
            end
            ST_FAILED: begin
                if (RETRY_REQ) begin
                    w_state_nxt = ST_HOLD;
                    w_retry_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_HOLD;
            end
        endcase
    end

    // Outputs are decoded from the next state so they move on the same edge
    // as STATE.
    always_ff @(posedge REFERENCECLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= ST_HOLD;
            r_hold_cnt  <= '0;
            r_tmo_cnt   <= '0;
            r_stab_cnt  <= '0;
            r_retry_cnt <= '0;
            r_relock    <= '0;
            PLL_RESETB  <= 1'b0;
            PLL_BYPASS  <= 1'b0;
            SYS_RESETN  <= 1'b0;
            FAILED      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_tmo_cnt   <= w_tmo_nxt;
            r_stab_cnt  <= w_stab_nxt;
            r_retry_cnt <= w_retry_nxt;
            r_relock    <= w_relock_nxt;
            PLL_RESETB  <= (w_state_nxt == ST_WAIT) || (w_state_nxt == ST_STABLE) ||
                           (w_state_nxt == ST_RUN);
            PLL_BYPASS  <= (w_state_nxt == ST_FAILED) && FALLBACK_BYPASS;
            SYS_RESETN  <= (w_state_nxt == ST_RUN) ||
                           ((w_state_nxt == ST_FAILED) && FALLBACK_BYPASS);
            FAILED      <= (w_state_nxt == ST_FAILED);
        end
    end

    assign STATE        = r_state;
    assign RELOCK_COUNT = r_relock;

endmodule : pll_supervisor
`default_nettype wire

// File: tb/tb_pll_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_supervisor
// Description : Directed self-checking bench for pll_supervisor. Expected
//               values go into a scoreboard queue as stimulus is applied and
//               are popped against what the design produces.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_supervisor;

    localparam int RST_CYCLES   = 4;
    localparam int LOCK_TIMEOUT = 32;
    localparam int LOCK_STABLE  = 8;
    localparam int MAX_RETRIES  = 2;
    localparam int CNT_W        = 4;

    localparam int S_RESETB = 0;
    localparam int S_SYSRST = 1;

    logic             clk = 1'b0;
    logic             RESET;
    logic             LOCK;
    logic             RETRY_REQ;
    logic             PLL_RESETB;
    logic             PLL_BYPASS;
    logic             SYS_RESETN;
    logic [2:0]       STATE;
    logic             FAILED;
    logic [CNT_W-1:0] RELOCK_COUNT;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   n;

    pll_supervisor #(
        .RST_CYCLES      (RST_CYCLES),
        .LOCK_TIMEOUT    (LOCK_TIMEOUT),
        .LOCK_STABLE     (LOCK_STABLE),
        .MAX_RETRIES     (MAX_RETRIES),
        .FALLBACK_BYPASS (1'b1),
        .CNT_W           (CNT_W)
    ) dut (
        .REFERENCECLK (clk),
        .RESET        (RESET),
        .LOCK         (LOCK),
        .RETRY_REQ    (RETRY_REQ),
        .PLL_RESETB   (PLL_RESETB),
        .PLL_BYPASS   (PLL_BYPASS),
        .SYS_RESETN   (SYS_RESETN),
        .STATE        (STATE),
        .FAILED       (FAILED),
        .RELOCK_COUNT (RELOCK_COUNT)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] get_sig(input int sel);
        case (sel)
            S_RESETB: return {31'd0, PLL_RESETB};
            default:  return {31'd0, SYS_RESETN};
        endcase
    endfunction

    // Counts edges until the selected output shows val, capped at budget.
    task automatic wait_for(input int sel, input logic [31:0] val, input int budget,
                            output int cycles);
        cycles = 0;
        while ((get_sig(sel) !== val) && (cycles < budget)) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic sb_chk(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            e.tag = "sb_underflow";
            e.val = 32'hx;
        end else begin
            e = sb.pop_front();
        end
        assert (obs === e.val)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
        end
    endtask

    task automatic restart(input logic lock_val);
        RESET = 1'b0;
        LOCK  = lock_val;
        step(2);
        RESET = 1'b1;
    endtask

    initial begin
        RESET     = 1'b0;
        LOCK      = 1'b0;
        RETRY_REQ = 1'b0;
        step(3);

        // Reset values
        sb_push("rst_state", 0);  sb_chk(STATE);
        sb_push("rst_resetb", 0); sb_chk(PLL_RESETB);
        sb_push("rst_bypass", 0); sb_chk(PLL_BYPASS);
        sb_push("rst_sysrst", 0); sb_chk(SYS_RESETN);
        sb_push("rst_failed", 0); sb_chk(FAILED);
        sb_push("rst_relock", 0); sb_chk(RELOCK_COUNT);

        // Clean lock
        RESET = 1'b1;
        sb_push("clean_hold_len", RST_CYCLES);
        wait_for(S_RESETB, 1, 20, n); sb_chk(n);
        step(10);
        LOCK = 1'b1;
        sb_push("clean_lock_lat", 2 + LOCK_STABLE);
        wait_for(S_SYSRST, 1, 40, n); sb_chk(n);
        sb_push("clean_state", 3);  sb_chk(STATE);
        sb_push("clean_resetb", 1); sb_chk(PLL_RESETB);

        // RETRY_REQ has no effect outside FAILED
        RETRY_REQ = 1'b1;
        step(1);
        RETRY_REQ = 1'b0;
        step(2);
        sb_push("retry_ignored", 3); sb_chk(STATE);

        // Chatter: one low cycle sends STABLE back to WAIT
        restart(1'b0);
        sb_push("chat_hold_len", RST_CYCLES);
        wait_for(S_RESETB, 1, 20, n); sb_chk(n);
        LOCK = 1'b1;
        step(5);
        LOCK = 1'b0;
        step(1);
        LOCK = 1'b1;
        step(2);
        sb_push("chat_back_wait", 1); sb_chk(STATE);
        sb_push("chat_lock_lat", 2 + LOCK_STABLE - 2);
        wait_for(S_SYSRST, 1, 40, n); sb_chk(n);
        sb_push("chat_relock", 0); sb_chk(RELOCK_COUNT);

        // Runtime lock loss, RELOCK_COUNT saturates
        for (int i = 0; i < 17; i++) begin
            LOCK = 1'b0;
            sb_push("loss_drop_lat", 3);
            wait_for(S_SYSRST, 0, 10, n); sb_chk(n);
            LOCK = 1'b1;
            sb_push("loss_relock_lat", RST_CYCLES + LOCK_STABLE);
            wait_for(S_SYSRST, 1, 60, n); sb_chk(n);
            sb_push("loss_count", (i + 1 > 15) ? 15 : i + 1);
            sb_chk(RELOCK_COUNT);
        end

        // Async reset while in STABLE
        LOCK = 1'b0;
        sb_push("pre_rst_drop_lat", 3);
        wait_for(S_SYSRST, 0, 10, n); sb_chk(n);
        LOCK = 1'b1;
        step(6);
        sb_push("pre_rst_state", 2);  sb_chk(STATE);
        sb_push("pre_rst_relock", 15); sb_chk(RELOCK_COUNT);
        #3;
        RESET = 1'b0;
        #1;
        sb_push("arst_state", 0);  sb_chk(STATE);
        sb_push("arst_resetb", 0); sb_chk(PLL_RESETB);
        sb_push("arst_sysrst", 0); sb_chk(SYS_RESETN);
        sb_push("arst_relock", 0); sb_chk(RELOCK_COUNT);
        @(posedge clk);
        #1;
        RESET = 1'b1;
        sb_push("arst_hold_len", RST_CYCLES);
        wait_for(S_RESETB, 1, 20, n); sb_chk(n);

        // Timeout boundary: qualification on the last window cycle enters RUN
        restart(1'b0);
        wait_for(S_RESETB, 1, 20, n);
        step(LOCK_TIMEOUT - 10);
        LOCK = 1'b1;
        step(10);
        sb_push("bound_run_state", 3); sb_chk(STATE);
        sb_push("bound_run_sysrst", 1); sb_chk(SYS_RESETN);

        // One cycle later is too late: the timeout wins
        restart(1'b0);
        wait_for(S_RESETB, 1, 20, n);
        step(LOCK_TIMEOUT - 9);
        LOCK = 1'b1;
        step(10);
        sb_push("bound_late_state", 0); sb_chk(STATE);
        sb_push("bound_late_sysrst", 0); sb_chk(SYS_RESETN);

        // Timeout, retries, FAILED with bypass, then RETRY_REQ
        restart(1'b0);
        for (int a = 0; a <= MAX_RETRIES; a++) begin
            sb_push("tmo_hold_len", RST_CYCLES);
            wait_for(S_RESETB, 1, 20, n); sb_chk(n);
            sb_push("tmo_wait_len", LOCK_TIMEOUT);
            wait_for(S_RESETB, 0, 60, n); sb_chk(n);
        end
        sb_push("fail_flag", 1);   sb_chk(FAILED);
        sb_push("fail_bypass", 1); sb_chk(PLL_BYPASS);
        sb_push("fail_sysrst", 1); sb_chk(SYS_RESETN);
        sb_push("fail_resetb", 0); sb_chk(PLL_RESETB);
        sb_push("fail_state", 4);  sb_chk(STATE);
        step(5);
        sb_push("fail_stays", 4);  sb_chk(STATE);
        RETRY_REQ = 1'b1;
        step(1);
        RETRY_REQ = 1'b0;
        sb_push("retry_state", 0);  sb_chk(STATE);
        sb_push("retry_bypass", 0); sb_chk(PLL_BYPASS);
        sb_push("retry_sysrst", 0); sb_chk(SYS_RESETN);
        sb_push("retry_failed", 0); sb_chk(FAILED);
        sb_push("retry_hold_len", RST_CYCLES);
        wait_for(S_RESETB, 1, 20, n); sb_chk(n);

        total++;
        assert (sb.size() == 0)
        else begin
            bad++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pll_supervisor
`default_nettype wire
